// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop rx synchronizer, mid-bit sampling, one-cycle data_av strobe.
// Optional macro UART_RX_FRAME_ERR_EN adds a one-cycle frame_err pulse on a bad stop bit.
//
// state   | meaning
// S_IDLE  | line idle, waiting for rx_s low
// S_START | timing half a bit to confirm the start bit
// S_DATA  | sampling 8 data bits at mid-bit, LSB first
// S_STOP  | sampling stop bit; after a bad stop, waits for rx_s high
module uart_receiver #(
  parameter int RATE_FREQ_BAUD = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_av
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int            HALF    = RATE_FREQ_BAUD / 2;
  localparam int            CW      = $clog2(RATE_FREQ_BAUD);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(RATE_FREQ_BAUD - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_brk;
  logic [7:0]    r_data_out;
  logic          r_data_av;
  logic          w_tc;
  logic          w_in_idle;
  logic          w_load_half;
  logic          w_load_bit;
  logic          w_hold;
  logic          w_shift_en;
  logic          w_byte_ok;
  logic          w_frame_bad;

  assign w_tc = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_state_nxt = S_START;
      S_START: if (w_tc) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tc && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP: begin
        // after a bad stop bit, stay here until the line goes high so a break yields nothing
        if (r_brk) begin
          if (r_rx_s) w_state_nxt = S_IDLE;
        end else if (w_tc && r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_idle   = 1'b0;
    w_load_half = 1'b0;
    w_load_bit  = 1'b0;
    w_hold      = 1'b0;
    w_shift_en  = 1'b0;
    w_byte_ok   = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_idle   = 1'b1;
        w_load_half = 1'b1;
      end
      S_START: w_load_bit = w_tc;
      S_DATA: begin
        w_load_bit = w_tc;
        w_shift_en = w_tc;
      end
      S_STOP: begin
        w_hold = r_brk | w_tc;
        if (!r_brk && w_tc) begin
          w_byte_ok   = r_rx_s;
          w_frame_bad = ~r_rx_s;
        end
      end
      default: w_in_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_brk      <= 1'b0;
      r_data_out <= 8'h00;
      r_data_av  <= 1'b0;
    end else begin
      if (w_load_half)     r_cnt <= HALF_LD;
      else if (w_load_bit) r_cnt <= BIT_LD;
      else if (!w_hold)    r_cnt <= r_cnt - CW'(1);

      if (w_in_idle)       r_bit_idx <= 3'd0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
      if (w_byte_ok)  r_data_out <= r_shift;
      r_data_av <= w_byte_ok;

      if (w_frame_bad)    r_brk <= 1'b1;
      else if (w_in_idle) r_brk <= 1'b0;
    end
  end

  assign data_out = r_data_out;
  assign data_av  = r_data_av;

`ifdef UART_RX_FRAME_ERR_EN
  logic r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_frame_bad;
  end

  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frames are driven bit by bit; a queue of expected strobe cycles,
// derived from the start-edge time and the 8N1 sampling rules, is compared every cycle.
module tb_uart_receiver;

  localparam int B = 434;
  localparam int H = B / 2;

  logic       clk = 1'b1;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_av;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  always #5 clk = ~clk;

  uart_receiver #(.RATE_FREQ_BAUD(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_out (data_out),
    .data_av  (data_av)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  b;
    bit          ok;
  } ev_t;

  ev_t         q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_dout = 8'h00;
  int          av_cnt = 0;
  int          fe_cnt = 0;
  int unsigned last_av_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected strobe for a frame whose start edge was driven at cycle s: 2 synchronizer
  // cycles + 1 detect cycle + half bit + 9 bit periods, then visible after that edge.
  task automatic expect_frame(input int unsigned s, input logic [7:0] b, input bit ok);
    ev_t e;
    e.cyc = s + 3 + H + 9 * B;
    e.b   = b;
    e.ok  = ok;
    q.push_back(e);
  endtask

  task automatic compare();
    logic e_av;
`ifdef UART_RX_FRAME_ERR_EN
    logic e_fe;
`endif
    e_av = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    e_fe = 1'b0;
`endif
    if (rst) return;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      if (q[0].ok) begin
        e_av       = 1'b1;
        model_dout = q[0].b;
      end else begin
`ifdef UART_RX_FRAME_ERR_EN
        e_fe = 1'b1;
`endif
      end
      q.delete(0);
    end
    chk("data_av", data_av, e_av);
    chk("data_out", data_out, model_dout);
`ifdef UART_RX_FRAME_ERR_EN
    chk("frame_err", frame_err, e_fe);
    if (frame_err === 1'b1) fe_cnt++;
`endif
    if (data_av === 1'b1) begin
      av_cnt++;
      last_av_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_bit,
                            output int unsigned start);
    start = cyc;
    rx    = 1'b0;
    if (abort_bit < 0) expect_frame(start, b, stop_ok);
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      for (int k = 0; k < B; k++) begin
        if (i == abort_bit && k == B / 2) rst = 1'b1;
        tick();
        if (rst) begin
          rst        = 1'b0;
          q.delete();
          model_dout = 8'h00;
        end
      end
    end
    rx = stop_ok;
    repeat (B) tick();
    rx = 1'b1;
  endtask

  initial begin
    int unsigned s;
    int          a0;
    int          f0;
    bit          prev_bad;
    bit          bad;
    logic [7:0]  rb;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_data_av", data_av, 1'b0);

    // single frame, with hand-computed latency 3+217+9*434 = 4126
    idle(50);
    a0 = av_cnt;
    send_frame(8'h55, 1'b1, -1, s);
    idle(B);
    chk("t1_pulses", av_cnt - a0, 1);
    chk("t1_latency", last_av_cyc - s, 4126);
    chk("t1_data", data_out, 8'h55);

    // back-to-back frames with no idle gap
    a0 = av_cnt;
    send_frame(8'hA5, 1'b1, -1, s);
    chk("t2_first", data_out, 8'hA5);
    send_frame(8'h3C, 1'b1, -1, s);
    idle(B);
    chk("t2_pulses", av_cnt - a0, 2);
    chk("t2_second", data_out, 8'h3C);

    // short glitch is rejected, then a real frame
    a0 = av_cnt;
    rx = 1'b0;
    repeat (100) tick();
    idle(2 * B);
    chk("t3_glitch_pulses", av_cnt - a0, 0);
    send_frame(8'h81, 1'b1, -1, s);
    idle(B);
    chk("t3_pulses", av_cnt - a0, 1);
    chk("t3_data", data_out, 8'h81);

    // framing error keeps data_out
    a0 = av_cnt;
    f0 = fe_cnt;
    send_frame(8'hF0, 1'b0, -1, s);
    idle(2 * B);
    chk("t4_pulses", av_cnt - a0, 0);
    chk("t4_data_kept", data_out, 8'h81);
`ifdef UART_RX_FRAME_ERR_EN
    chk("t4_frame_err", fe_cnt - f0, 1);
`endif

    // reset in the middle of data bit 4 aborts the frame
    a0 = av_cnt;
    send_frame(8'hF3, 1'b1, 4, s);
    idle(2 * B);
    chk("t5_abort_pulses", av_cnt - a0, 0);
    chk("t5_abort_data", data_out, 8'h00);
    send_frame(8'h7E, 1'b1, -1, s);
    idle(B);
    chk("t5_pulses", av_cnt - a0, 1);
    chk("t5_data", data_out, 8'h7E);

    // line held low for 20 bit periods: one discarded frame at most
    a0 = av_cnt;
    f0 = fe_cnt;
    rx = 1'b0;
    expect_frame(cyc, 8'h00, 1'b0);
    repeat (20 * B) tick();
    idle(2 * B);
    chk("t6_break_pulses", av_cnt - a0, 0);
    chk("t6_break_data", data_out, 8'h7E);
`ifdef UART_RX_FRAME_ERR_EN
    chk("t6_break_frame_err", fe_cnt - f0, 1);
`endif
    send_frame(8'hC3, 1'b1, -1, s);
    idle(B);
    chk("t6_pulses", av_cnt - a0, 1);
    chk("t6_data", data_out, 8'hC3);

    // random bytes, random gaps (including none), occasional bad stop bit
    prev_bad = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rb  = 8'($urandom_range(255));
      bad = ($urandom_range(5) == 0);
      if (prev_bad) idle(int'($urandom_range(2 * B, 1)));
      else          idle(int'($urandom_range(2 * B, 0)));
      send_frame(rb, !bad, -1, s);
      prev_bad = bad;
    end
    idle(2 * B);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
